// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream program loader into instruction memory.
// Optional trailing XOR checksum byte enabled by INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int MAX_WORDS = 400
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] instr_wAddr,
    output logic [31:0] instr_wData,
    output logic        instr_we,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
`ifdef INSTR_LOADER_CHECKSUM_EN
        S_CHK   = 3'd4,
`endif
        S_DONE  = 3'd5
    } state_t;

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_byte_cnt;
    logic [15:0] r_word_cnt;
    logic [15:0] r_len;
    logic [23:0] r_shift;
    logic [31:0] r_waddr;
    logic [31:0] r_wdata;
    logic        r_error;
    logic        r_hold;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]  r_chk;
`endif

    logic        w_rx_ok;
    logic        w_accept;
    logic [15:0] w_len_full;
    logic        w_len_bad;
    logic        w_more;

`ifdef INSTR_LOADER_CHECKSUM_EN
    assign w_rx_ok = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
`else
    assign w_rx_ok = (r_state == S_LEN) || (r_state == S_DATA);
`endif
    assign w_accept   = rx_valid && w_rx_ok;
    // Length is complete only when its high byte arrives, so judge it from the live byte.
    assign w_len_full = {rx_data, r_len[7:0]};
    assign w_len_bad  = 32'(w_len_full) > 32'(MAX_WORDS);
    assign w_more     = ({1'b0, r_word_cnt} + 17'd1) < {1'b0, r_len};

    assign rx_ready    = w_rx_ok;
    assign instr_wAddr = r_waddr;
    assign instr_wData = r_wdata;
    assign cpu_hold    = r_hold;
    assign error       = r_error;

    always_comb begin
        w_next   = r_state;
        instr_we = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_accept && r_byte_cnt == 2'd1) begin
                    if (w_len_full == 16'd0) w_next = S_TAIL;
                    else if (w_len_bad)      w_next = S_IDLE;
                    else                     w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept && r_byte_cnt == 2'd3) w_next = S_WRITE;
            end
            S_WRITE: begin
                instr_we = 1'b1;
                w_next   = w_more ? S_DATA : S_TAIL;
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_accept) w_next = (rx_data == r_chk) ? S_DONE : S_IDLE;
            end
`endif
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= 2'd0;
            r_word_cnt <= 16'd0;
            r_len      <= 16'd0;
            r_shift    <= 24'd0;
            r_waddr    <= 32'd0;
            r_wdata    <= 32'd0;
            r_error    <= 1'b0;
            r_hold     <= 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_chk      <= 8'd0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_error    <= 1'b0;
                        r_byte_cnt <= 2'd0;
                        r_word_cnt <= 16'd0;
                        r_hold     <= 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        r_chk      <= 8'd0;
`endif
                    end
                end
                S_LEN: begin
                    if (w_accept) begin
                        if (r_byte_cnt == 2'd0) begin
                            r_len[7:0] <= rx_data;
                            r_byte_cnt <= 2'd1;
                        end else begin
                            r_len[15:8] <= rx_data;
                            r_byte_cnt  <= 2'd0;
                            if (w_len_bad) r_error <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_shift    <= {rx_data, r_shift[23:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        r_chk      <= r_chk ^ rx_data;
`endif
                        if (r_byte_cnt == 2'd3) begin
                            r_wdata <= {rx_data, r_shift};
                            r_waddr <= {14'd0, r_word_cnt, 2'b00};
                        end
                    end
                end
                S_WRITE: r_word_cnt <= r_word_cnt + 16'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_accept && rx_data != r_chk) r_error <= 1'b1;
                end
`endif
                S_DONE: r_hold <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - table-driven check of instr_loader loads plus stall/reset sequences.
module tb_instr_loader;

    localparam int MAX_W = 400;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] instr_wAddr;
    logic [31:0] instr_wData;
    logic        instr_we;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    instr_loader #(.MAX_WORDS(MAX_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .instr_wAddr(instr_wAddr), .instr_wData(instr_wData), .instr_we(instr_we),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        logic [31:0] base;
        logic [31:0] step;
        logic        bad_chk;
        int          exp_writes;
        logic        exp_done;
        logic        exp_error;
        logic        exp_hold;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wr_addr [1024];
    logic [31:0] wr_data [1024];
    logic        wr_ok   [1024];
    int          wr_n = 0;
    int          done_n = 0;

    always @(negedge clk) begin
        if (instr_we) begin
            wr_addr[wr_n % 1024] = instr_wAddr;
            wr_data[wr_n % 1024] = instr_wData;
            wr_ok[wr_n % 1024]   = !rx_ready && busy;
            wr_n = wr_n + 1;
        end
        if (done) done_n = done_n + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!rx_ready) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, "_we"},       {31'd0, instr_we}, 32'd0);
        chk({tag, "_waddr"},    instr_wAddr, 32'd0);
        chk({tag, "_wdata"},    instr_wData, 32'd0);
        chk({tag, "_busy"},     {31'd0, busy}, 32'd0);
        chk({tag, "_done"},     {31'd0, done}, 32'd0);
        chk({tag, "_error"},    {31'd0, error}, 32'd0);
        chk({tag, "_hold"},     {31'd0, cpu_hold}, 32'd1);
    endtask

    task automatic run_row(input vec_t v, input int idx);
        int          w0;
        int          d0;
        logic [7:0]  x;
        logic [31:0] w;
        string       tag;
        tag = $sformatf("row%0d", idx);
        w0 = wr_n;
        d0 = done_n;
        x  = 8'd0;
        pulse_start();
        send_byte(v.n[7:0]);
        send_byte(v.n[15:8]);
        if (int'(v.n) <= MAX_W) begin
            for (int i = 0; i < int'(v.n); i++) begin
                w = v.base + 32'(i) * v.step;
                for (int b = 0; b < 4; b++) begin
                    send_byte(w[8*b +: 8]);
                    x = x ^ w[8*b +: 8];
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            if (v.bad_chk) send_byte((x == 8'h00) ? 8'hFF : 8'h00);
            else           send_byte(x);
`endif
        end
        wait_idle();
        chk({tag, "_writes"}, 32'(wr_n - w0), 32'(v.exp_writes));
        chk({tag, "_done"},   32'(done_n - d0), {31'd0, v.exp_done});
        chk({tag, "_error"},  {31'd0, error}, {31'd0, v.exp_error});
        chk({tag, "_hold"},   {31'd0, cpu_hold}, {31'd0, v.exp_hold});
        for (int i = 0; i < v.exp_writes && i < wr_n - w0; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wr_addr[(w0 + i) % 1024], 32'(i) * 32'd4);
            chk($sformatf("%s_data%0d", tag, i), wr_data[(w0 + i) % 1024], v.base + 32'(i) * v.step);
            chk($sformatf("%s_wrcyc%0d", tag, i), {31'd0, wr_ok[(w0 + i) % 1024]}, 32'd1);
        end
    endtask

    vec_t tbl [10];
    int   n_rows;
    int   w0;
    int   d0;

    initial begin
        n_rows = 0;
        tbl[n_rows++] = '{16'd2,      32'h0010_0513, 32'h0010_0080, 1'b0, 2,   1'b1, 1'b0, 1'b0};
        tbl[n_rows++] = '{16'h0191,   32'h0,         32'h0,         1'b0, 0,   1'b0, 1'b1, 1'b1};
        tbl[n_rows++] = '{16'd1,      32'hDEAD_BEEF, 32'h0,         1'b0, 1,   1'b1, 1'b0, 1'b0};
        tbl[n_rows++] = '{16'd0,      32'h0,         32'h0,         1'b0, 0,   1'b1, 1'b0, 1'b0};
        tbl[n_rows++] = '{16'hFFFF,   32'h0,         32'h0,         1'b0, 0,   1'b0, 1'b1, 1'b1};
        tbl[n_rows++] = '{16'd400,    32'h1234_5678, 32'h0101_0101, 1'b0, 400, 1'b1, 1'b0, 1'b0};
        tbl[n_rows++] = '{16'd3,      32'hA5A5_0000, 32'h0000_1111, 1'b0, 3,   1'b1, 1'b0, 1'b0};
`ifdef INSTR_LOADER_CHECKSUM_EN
        tbl[n_rows++] = '{16'd2,      32'h0010_0513, 32'h0010_0080, 1'b1, 2,   1'b0, 1'b1, 1'b1};
        tbl[n_rows++] = '{16'd2,      32'h0010_0513, 32'h0010_0080, 1'b0, 2,   1'b1, 1'b0, 1'b0};
`endif

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < n_rows; r++) run_row(tbl[r], r);

        // Stall mid-word with junk on rx_data and a stray start pulse.
        w0 = wr_n;
        d0 = done_n;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        rx_data = 8'hEE;
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            @(negedge clk);
            chk($sformatf("stall%0d", c), {29'd0, busy, rx_ready, instr_we}, 32'b110);
        end
        start = 1'b0;
        send_byte(8'h33);
        send_byte(8'h44);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
`endif
        wait_idle();
        chk("stall_writes", 32'(wr_n - w0), 32'd1);
        chk("stall_data", wr_data[w0 % 1024], 32'h4433_2211);
        chk("stall_addr", wr_addr[w0 % 1024], 32'd0);
        chk("stall_done", 32'(done_n - d0), 32'd1);

        // Reset asserted while the third data byte is on the bus.
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hA1);
        send_byte(8'hB2);
        rx_data  = 8'hC3;
        rx_valid = 1'b1;
        reset_n  = 1'b0;
        w0 = wr_n;
        @(negedge clk);
        check_reset_outputs("midreset");
        rx_valid = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midreset_nowrite", 32'(wr_n - w0), 32'd0);
        run_row(tbl[0], 99);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
